// File: rtl/core_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_bus_pkg
// Purpose  : Shared types, size encodings and byte-lane helper functions for
//            the core-side request/grant to Wishbone-classic bridge.
// Revision : 1.0 - initial release
// ============================================================================
package core_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Byte-lane enables for an access of the given size at byte offset alo.
    function automatic logic [3:0] sel_from_size(input logic [1:0] size,
                                                 input logic [1:0] alo);
        logic [3:0] sel;
        case (size)
            SIZE_BYTE: sel = 4'b0001 << alo;
            SIZE_HALF: sel = 4'b0011 << alo;
            SIZE_WORD: sel = 4'b1111;
            default:   sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // Replicate right-aligned write data into every lane it may land on.
    function automatic logic [31:0] align_wdata(input logic [1:0]  size,
                                                input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            SIZE_BYTE: d = {4{wd[7:0]}};
            SIZE_HALF: d = {2{wd[15:0]}};
            default:   d = wd;
        endcase
        return d;
    endfunction

    // Shift the addressed lanes down, mask to size, then sign/zero extend.
    function automatic logic [31:0] extract_rdata(input logic [1:0]  size,
                                                  input logic        usgn,
                                                  input logic [1:0]  alo,
                                                  input logic [31:0] dat);
        logic [31:0] sh;
        logic [31:0] r;
        sh = dat >> {alo, 3'b000};
        case (size)
            SIZE_BYTE: r = usgn ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SIZE_HALF: r = usgn ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default:   r = dat;
        endcase
        return r;
    endfunction

    // Sub-word accesses must sit on their natural boundary; size 11 is reserved.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] alo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = alo[0];
            SIZE_WORD: bad = |alo;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage : core_bus_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : N-way arbiter, round-robin or fixed (lowest index wins).
//            Combinational select, registered priority pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 2,
    parameter bit FIXED = 1'b0,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     i_req,
    input  logic             i_advance,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Index of the highest-priority port; the last winner drops to lowest.
    logic [IDX_W-1:0] r_ptr;
    int               w_cand;

    // Scan ports starting at the pointer and pick the first requester.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        for (int i = 0; i < N; i++) begin
            w_cand = (FIXED ? 0 : int'(r_ptr)) + i;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_idx           = IDX_W'(w_cand);
                o_grant[w_cand] = 1'b1;
            end
        end
    end

    // Move the pointer just past the winner whenever a grant is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && o_valid) begin
            r_ptr <= (int'(o_idx) >= N - 1) ? '0 : o_idx + IDX_W'(1);
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/core_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : core_bus_arbiter
// Purpose  : N-port request/grant to Wishbone-classic master bridge with
//            lane steering, read extension, misalign check and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module core_bus_arbiter
    import core_bus_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [NUM_PORTS-1:0]            req_i,
    input  logic [NUM_PORTS-1:0]            we_i,
    input  logic [2*NUM_PORTS-1:0]          size_i,
    input  logic [NUM_PORTS-1:0]            usgn_i,
    input  logic [ADDR_WIDTH*NUM_PORTS-1:0] addr_i,
    input  logic [32*NUM_PORTS-1:0]         wdata_i,
    output logic [NUM_PORTS-1:0]            gnt_o,
    output logic [NUM_PORTS-1:0]            err_o,
    output logic [31:0]                     rdata_o,
    output logic                            wb_cyc_o,
    output logic                            wb_stb_o,
    output logic                            wb_we_o,
    output logic [3:0]                      wb_sel_o,
    output logic [ADDR_WIDTH-1:0]           wb_adr_o,
    output logic [31:0]                     wb_dat_o,
    input  logic [31:0]                     wb_dat_i,
    input  logic                            wb_ack_i,
    input  logic                            wb_err_i
);

    localparam int c_IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam int c_TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    generate
        if (DATA_WIDTH != 32) begin : g_width_check
            $error("core_bus_arbiter: only DATA_WIDTH=32 is supported");
        end
    endgenerate

    state_e                  r_state, w_state_n;
    logic                    r_cyc, w_cyc_n;
    logic                    r_we, w_we_n;
    logic [3:0]              r_sel, w_sel_n;
    logic [ADDR_WIDTH-1:0]   r_adr, w_adr_n;
    logic [31:0]             r_dat, w_dat_n;
    logic [NUM_PORTS-1:0]    r_gnt, w_gnt_n;
    logic [NUM_PORTS-1:0]    r_err, w_err_n;
    logic [31:0]             r_rdata, w_rdata_n;
    logic [NUM_PORTS-1:0]    r_owner, w_owner_n;
    logic [1:0]              r_size, w_size_n;
    logic                    r_usgn, w_usgn_n;
    logic [1:0]              r_alo, w_alo_n;
    logic [c_CNT_W-1:0]      r_cnt, w_cnt_n;

    logic [NUM_PORTS-1:0]    w_arb_grant;
    logic [c_IDX_W-1:0]      w_arb_idx;
    logic                    w_arb_valid;
    logic                    w_advance;
    logic [1:0]              w_sel_size;
    logic                    w_sel_usgn;
    logic                    w_sel_we;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [31:0]             w_sel_wdata;
    logic                    w_tmo;

    // Arbitration only happens from IDLE, so the owner's held request
    // cannot re-issue while its response is on the outputs.
    assign w_advance = (r_state == IDLE);

    rr_arbiter #(
        .N     (NUM_PORTS),
        .FIXED (FIXED_PRIORITY != 0),
        .IDX_W (c_IDX_W)
    ) u_arb (
        .clk       (clk_i),
        .rst_n     (rstn_i),
        .i_req     (req_i),
        .i_advance (w_advance),
        .o_grant   (w_arb_grant),
        .o_idx     (w_arb_idx),
        .o_valid   (w_arb_valid)
    );

    assign w_sel_size  = size_i[2*int'(w_arb_idx) +: 2];
    assign w_sel_usgn  = usgn_i[w_arb_idx];
    assign w_sel_we    = we_i[w_arb_idx];
    assign w_sel_addr  = addr_i[ADDR_WIDTH*int'(w_arb_idx) +: ADDR_WIDTH];
    assign w_sel_wdata = wdata_i[32*int'(w_arb_idx) +: 32];

    assign w_tmo = (TIMEOUT_CYCLES != 0) && (r_cnt == c_TMO_LAST[c_CNT_W-1:0]);

    // Next state plus the next value of every registered output and latch.
    always_comb begin
        w_state_n = r_state;
        w_cyc_n   = r_cyc;
        w_we_n    = r_we;
        w_sel_n   = r_sel;
        w_adr_n   = r_adr;
        w_dat_n   = r_dat;
        w_gnt_n   = '0;
        w_err_n   = '0;
        w_rdata_n = r_rdata;
        w_owner_n = r_owner;
        w_size_n  = r_size;
        w_usgn_n  = r_usgn;
        w_alo_n   = r_alo;
        w_cnt_n   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_owner_n = w_arb_grant;
                    w_size_n  = w_sel_size;
                    w_usgn_n  = w_sel_usgn;
                    w_alo_n   = w_sel_addr[1:0];
                    if (is_misaligned(w_sel_size, w_sel_addr[1:0])) begin
                        w_state_n = RESP;
                        w_err_n   = w_arb_grant;
                        w_rdata_n = '0;
                    end else begin
                        w_state_n = BUS;
                        w_cyc_n   = 1'b1;
                        w_we_n    = w_sel_we;
                        w_sel_n   = sel_from_size(w_sel_size, w_sel_addr[1:0]);
                        w_adr_n   = {w_sel_addr[ADDR_WIDTH-1:2], 2'b00};
                        w_dat_n   = align_wdata(w_sel_size, w_sel_wdata);
                        w_cnt_n   = '0;
                    end
                end
            end
            BUS: begin
                if (wb_err_i) begin
                    w_state_n = RESP;
                    w_cyc_n   = 1'b0;
                    w_err_n   = r_owner;
                    w_rdata_n = '0;
                    w_cnt_n   = '0;
                end else if (wb_ack_i) begin
                    w_state_n = RESP;
                    w_cyc_n   = 1'b0;
                    w_gnt_n   = r_owner;
                    w_rdata_n = extract_rdata(r_size, r_usgn, r_alo, wb_dat_i);
                    w_cnt_n   = '0;
                end else if (w_tmo) begin
                    w_state_n = RESP;
                    w_cyc_n   = 1'b0;
                    w_err_n   = r_owner;
                    w_rdata_n = '0;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n   = r_cnt + c_CNT_W'(1);
                end
            end
            RESP: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Output, transaction-latch and timeout-counter registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_gnt   <= '0;
            r_err   <= '0;
            r_rdata <= '0;
            r_owner <= '0;
            r_size  <= '0;
            r_usgn  <= 1'b0;
            r_alo   <= '0;
            r_cnt   <= '0;
        end else begin
            r_cyc   <= w_cyc_n;
            r_we    <= w_we_n;
            r_sel   <= w_sel_n;
            r_adr   <= w_adr_n;
            r_dat   <= w_dat_n;
            r_gnt   <= w_gnt_n;
            r_err   <= w_err_n;
            r_rdata <= w_rdata_n;
            r_owner <= w_owner_n;
            r_size  <= w_size_n;
            r_usgn  <= w_usgn_n;
            r_alo   <= w_alo_n;
            r_cnt   <= w_cnt_n;
        end
    end

    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign wb_we_o  = r_we;
    assign wb_sel_o = r_sel;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign gnt_o    = r_gnt;
    assign err_o    = r_err;
    assign rdata_o  = r_rdata;

endmodule : core_bus_arbiter
`default_nettype wire
